// File: rtl/wm_cycle_ctrl.sv
// Washing-machine cycle controller: Fill, Wash, Drain, (Rinse, Drain) x RINSE_CNT, Spin, Done,
// with quick mode, pause and abort. Define WM_DOOR_LOCK_EN to add the door_closed / door_lock interlock.
module wm_cycle_ctrl #(
    parameter int unsigned TIMER_W   = 8,
    parameter int unsigned FILL_T    = 10,
    parameter int unsigned WASH_T    = 40,
    parameter int unsigned DRAIN_T   = 8,
    parameter int unsigned RINSE_T   = 20,
    parameter int unsigned SPIN_T    = 30,
    parameter int unsigned RINSE_CNT = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_button,
    input  logic       pause_button,
    input  logic       abort,
    input  logic       quick_mode,
`ifdef WM_DOOR_LOCK_EN
    input  logic       door_closed,
    output logic       door_lock,
`endif
    output logic [2:0] state,
    output logic       water_valve,
    output logic       motor_on,
    output logic       motor_fast,
    output logic       drain_pump,
    output logic       busy,
    output logic       paused,
    output logic       out
);

    typedef enum logic [2:0] {
        S_OFF   = 3'b000,
        S_FILL  = 3'b001,
        S_WASH  = 3'b010,
        S_DRAIN = 3'b011,
        S_RINSE = 3'b100,
        S_SPIN  = 3'b101,
        S_DONE  = 3'b110
    } state_e;

    localparam int unsigned WASH_QT = (WASH_T / 2 < 1) ? 1 : WASH_T / 2;
    localparam int unsigned RINSE_QT = (RINSE_T / 2 < 1) ? 1 : RINSE_T / 2;

    localparam logic [TIMER_W-1:0] FILL_LAST    = TIMER_W'(FILL_T - 1);
    localparam logic [TIMER_W-1:0] WASH_LAST    = TIMER_W'(WASH_T - 1);
    localparam logic [TIMER_W-1:0] WASH_QLAST   = TIMER_W'(WASH_QT - 1);
    localparam logic [TIMER_W-1:0] DRAIN_LAST   = TIMER_W'(DRAIN_T - 1);
    localparam logic [TIMER_W-1:0] RINSE_LAST   = TIMER_W'(RINSE_T - 1);
    localparam logic [TIMER_W-1:0] RINSE_QLAST  = TIMER_W'(RINSE_QT - 1);
    localparam logic [TIMER_W-1:0] SPIN_LAST    = TIMER_W'(SPIN_T - 1);
    localparam logic [2:0]         RINSE_N      = 3'(RINSE_CNT);

    state_e             state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [2:0]         rinse_q, rinse_d;
    logic               abort_q, abort_d;
    logic               quick_q, quick_d;
    logic               start_q;
    logic               paused_d;
    logic [TIMER_W-1:0] phase_last;
    logic               start_edge, active, hold;
    logic               door_ok, door_open;

`ifdef WM_DOOR_LOCK_EN
    assign door_ok   = door_closed;
    assign door_open = ~door_closed;
`else
    assign door_ok   = 1'b1;
    assign door_open = 1'b0;
`endif

    assign start_edge = start_button & ~start_q;
    assign active     = (state_q != S_OFF) && (state_q != S_DONE);
    assign hold       = active && (pause_button || door_open);
    assign state      = state_q;

    always_comb begin
        phase_last = FILL_LAST;
        case (state_q)
            S_WASH:  phase_last = quick_q ? WASH_QLAST : WASH_LAST;
            S_DRAIN: phase_last = DRAIN_LAST;
            S_RINSE: phase_last = quick_q ? RINSE_QLAST : RINSE_LAST;
            S_SPIN:  phase_last = SPIN_LAST;
            default: phase_last = FILL_LAST;
        endcase
    end

    always_comb begin
        // NOTE: every next-state variable gets a default here so no path leaves one unassigned (no latches).
        state_d  = state_q;
        timer_d  = timer_q;
        rinse_d  = rinse_q;
        abort_d  = abort_q;
        quick_d  = quick_q;
        paused_d = 1'b0;
        case (state_q)
            S_OFF: begin
                timer_d = '0;
                if (start_edge && door_ok) begin
                    state_d = S_FILL;
                    quick_d = quick_mode;
                end
            end
            S_DONE: begin
                state_d = S_OFF;
                timer_d = '0;
            end
            default: begin
                if (abort && state_q != S_DRAIN) begin
                    // Abort outranks pause: the drain starts immediately and unpaused.
                    state_d = S_DRAIN;
                    timer_d = '0;
                    abort_d = 1'b1;
                end else begin
                    if (abort) abort_d = 1'b1;
                    if (hold) begin
                        paused_d = 1'b1;
                    end else if (timer_q == phase_last) begin
                        timer_d = '0;
                        case (state_q)
                            S_FILL:  state_d = S_WASH;
                            S_WASH:  state_d = S_DRAIN;
                            S_RINSE: begin
                                state_d = S_DRAIN;
                                rinse_d = rinse_q + 3'd1;
                            end
                            S_DRAIN: begin
                                if (abort_d)                state_d = S_OFF;
                                else if (rinse_q < RINSE_N) state_d = S_RINSE;
                                else                        state_d = S_SPIN;
                            end
                            default: state_d = S_DONE;
                        endcase
                    end else begin
                        timer_d = timer_q + TIMER_W'(1);
                    end
                end
            end
        endcase
        if (state_d == S_OFF && state_q != S_OFF) begin
            rinse_d = '0;
            abort_d = 1'b0;
        end
    end

    // Outputs are decoded from next state so they appear registered in the same cycle as state.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_OFF;
            timer_q     <= '0;
            rinse_q     <= '0;
            abort_q     <= 1'b0;
            quick_q     <= 1'b0;
            start_q     <= 1'b0;
            paused      <= 1'b0;
            water_valve <= 1'b0;
            motor_on    <= 1'b0;
            motor_fast  <= 1'b0;
            drain_pump  <= 1'b0;
            busy        <= 1'b0;
            out         <= 1'b0;
`ifdef WM_DOOR_LOCK_EN
            door_lock   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            rinse_q     <= rinse_d;
            abort_q     <= abort_d;
            quick_q     <= quick_d;
            start_q     <= start_button;
            paused      <= paused_d;
            water_valve <= !paused_d && (state_d == S_FILL || state_d == S_RINSE);
            motor_on    <= !paused_d && (state_d == S_WASH || state_d == S_RINSE || state_d == S_SPIN);
            motor_fast  <= !paused_d && (state_d == S_SPIN);
            drain_pump  <= !paused_d && (state_d == S_DRAIN || state_d == S_SPIN);
            busy        <= (state_d != S_OFF) && (state_d != S_DONE);
            out         <= (state_d == S_DONE);
`ifdef WM_DOOR_LOCK_EN
            door_lock   <= (state_d != S_OFF);
`endif
        end
    end

endmodule

// File: tb/tb_wm_cycle_ctrl.sv
// Directed bench for wm_cycle_ctrl with default parameters; door-lock scenario runs when WM_DOOR_LOCK_EN is defined.
module tb_wm_cycle_ctrl;

    logic       clk, reset;
    logic       start_button, pause_button, abort, quick_mode;
    logic [2:0] state;
    logic       water_valve, motor_on, motor_fast, drain_pump, busy, paused, out;
`ifdef WM_DOOR_LOCK_EN
    logic       door_closed, door_lock;
`endif

    wm_cycle_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .start_button (start_button),
        .pause_button (pause_button),
        .abort        (abort),
        .quick_mode   (quick_mode),
`ifdef WM_DOOR_LOCK_EN
        .door_closed  (door_closed),
        .door_lock    (door_lock),
`endif
        .state        (state),
        .water_valve  (water_valve),
        .motor_on     (motor_on),
        .motor_fast   (motor_fast),
        .drain_pump   (drain_pump),
        .busy         (busy),
        .paused       (paused),
        .out          (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc, out_at, out_len;
    bit         timed_out;
    logic [2:0] last_state;
    logic [2:0] seq_q[$];
    logic [2:0] exp_seq[10] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd3, 3'd4, 3'd3, 3'd5, 3'd6, 3'd0};

    task automatic tick_obs();
        @(posedge clk); #1;
        cyc++;
        if (state !== last_state) begin
            seq_q.push_back(state);
            last_state = state;
        end
        if (out === 1'b1) begin
            if (out_len == 0) out_at = cyc;
            out_len++;
        end
    endtask

    task automatic init_obs();
        cyc = 0; out_at = -1; out_len = 0; timed_out = 1'b0;
        seq_q.delete();
        seq_q.push_back(state);
        last_state = state;
    endtask

    task automatic begin_run(input logic qm);
        quick_mode   = qm;
        start_button = 1'b1;
        @(posedge clk); #1;
        start_button = 1'b0;
        quick_mode   = 1'b0;
        init_obs();
    endtask

    task automatic run_to_off(input int budget);
        int guard = 0;
        while (state !== 3'd0 && guard < budget) begin
            tick_obs();
            guard++;
        end
        timed_out = (state !== 3'd0);
    endtask

    function automatic bit seq_matches();
        if (seq_q.size() != 10) return 1'b0;
        for (int i = 0; i < 10; i++) if (seq_q[i] !== exp_seq[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic test_reset();
        reset = 1'b0;
        #12;
        n_cmp++;
        if ({state, water_valve, motor_on, motor_fast, drain_pump, busy, paused, out} !== 10'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %b want all zero", {state, water_valve, motor_on, motor_fast, drain_pump, busy, paused, out});
        end
        @(posedge clk); #1;
        reset = 1'b1;
        pause_button = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (state !== 3'd0 || paused !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_pause_ignored: got state=%0d paused=%b want state=0 paused=0", state, paused);
        end
        pause_button = 1'b0;
    endtask

    task automatic test_normal();
        begin_run(1'b0);
        n_cmp++;
        if (state !== 3'd1 || water_valve !== 1'b1 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL start_to_fill: got state=%0d wv=%b busy=%b want 1/1/1", state, water_valve, busy);
        end
        repeat (20) tick_obs();
        start_button = 1'b1;
        tick_obs();
        start_button = 1'b0;
        n_cmp++;
        if (state !== 3'd2 || motor_on !== 1'b1) begin
            n_bad++;
            $display("FAIL start_ignored_wash: got state=%0d motor_on=%b want 2/1", state, motor_on);
        end
        run_to_off(400);
        n_cmp++;
        if (timed_out || !seq_matches()) begin
            n_bad++;
            $display("FAIL normal_sequence: got %0d states (timeout=%b) want 1,2,3,4,3,4,3,5,6,0", seq_q.size(), timed_out);
        end
        n_cmp++;
        if (out_at !== 144 || out_len !== 1) begin
            n_bad++;
            $display("FAIL normal_out_timing: got out_at=%0d len=%0d want 144/1", out_at, out_len);
        end
    endtask

    task automatic test_quick();
        begin_run(1'b1);
        run_to_off(400);
        n_cmp++;
        if (timed_out || !seq_matches()) begin
            n_bad++;
            $display("FAIL quick_sequence: got %0d states (timeout=%b) want 10", seq_q.size(), timed_out);
        end
        n_cmp++;
        if (out_at !== 104 || out_len !== 1) begin
            n_bad++;
            $display("FAIL quick_out_timing: got out_at=%0d len=%0d want 104/1", out_at, out_len);
        end
    endtask

    task automatic test_pause();
        int bad_cycles = 0;
        begin_run(1'b0);
        repeat (15) tick_obs();
        pause_button = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick_obs();
            if (paused !== 1'b1 || motor_on !== 1'b0 || state !== 3'd2) bad_cycles++;
        end
        pause_button = 1'b0;
        n_cmp++;
        if (bad_cycles !== 0) begin
            n_bad++;
            $display("FAIL pause_hold: got %0d bad held cycles want 0", bad_cycles);
        end
        tick_obs();
        n_cmp++;
        if (paused !== 1'b0 || motor_on !== 1'b1) begin
            n_bad++;
            $display("FAIL pause_release: got paused=%b motor_on=%b want 0/1", paused, motor_on);
        end
        run_to_off(400);
        n_cmp++;
        if (timed_out || out_at !== 150 || out_len !== 1) begin
            n_bad++;
            $display("FAIL pause_out_timing: got out_at=%0d len=%0d timeout=%b want 150/1/0", out_at, out_len, timed_out);
        end
    endtask

    task automatic test_abort();
        begin_run(1'b0);
        repeat (34) tick_obs();
        abort = 1'b1;
        tick_obs();
        abort = 1'b0;
        n_cmp++;
        if (state !== 3'd3 || drain_pump !== 1'b1 || busy !== 1'b1 || motor_on !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_to_drain: got state=%0d dp=%b busy=%b mo=%b want 3/1/1/0", state, drain_pump, busy, motor_on);
        end
        repeat (7) tick_obs();
        n_cmp++;
        if (state !== 3'd3 || drain_pump !== 1'b1) begin
            n_bad++;
            $display("FAIL abort_drain_len: got state=%0d dp=%b want 3/1", state, drain_pump);
        end
        tick_obs();
        n_cmp++;
        if (state !== 3'd0 || busy !== 1'b0 || drain_pump !== 1'b0 || out_len !== 0) begin
            n_bad++;
            $display("FAIL abort_to_off: got state=%0d busy=%b dp=%b out_cycles=%0d want 0/0/0/0", state, busy, drain_pump, out_len);
        end
        begin_run(1'b0);
        run_to_off(400);
        n_cmp++;
        if (timed_out || !seq_matches() || out_at !== 144) begin
            n_bad++;
            $display("FAIL abort_then_full: got out_at=%0d states=%0d want 144/10", out_at, seq_q.size());
        end
    endtask

    task automatic test_reset_mid();
        begin_run(1'b0);
        repeat (140) tick_obs();
        n_cmp++;
        if (state !== 3'd5 || motor_fast !== 1'b1 || drain_pump !== 1'b1) begin
            n_bad++;
            $display("FAIL reach_spin: got state=%0d mf=%b dp=%b want 5/1/1", state, motor_fast, drain_pump);
        end
        #3;
        reset = 1'b0;
        start_button = 1'b1;
        #1;
        n_cmp++;
        if ({state, water_valve, motor_on, motor_fast, drain_pump, busy, paused, out} !== 10'd0) begin
            n_bad++;
            $display("FAIL async_reset: got %b want all zero", {state, water_valve, motor_on, motor_fast, drain_pump, busy, paused, out});
        end
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (state !== 3'd1 || water_valve !== 1'b1) begin
            n_bad++;
            $display("FAIL held_start_after_reset: got state=%0d wv=%b want 1/1", state, water_valve);
        end
        start_button = 1'b0;
        init_obs();
        run_to_off(400);
        n_cmp++;
        if (timed_out || !seq_matches() || out_at !== 144) begin
            n_bad++;
            $display("FAIL fresh_after_reset: got out_at=%0d states=%0d want 144/10", out_at, seq_q.size());
        end
    endtask

`ifdef WM_DOOR_LOCK_EN
    task automatic test_door();
        int guard = 0;
        door_closed  = 1'b0;
        start_button = 1'b1;
        @(posedge clk); #1;
        start_button = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (state !== 3'd0 || door_lock !== 1'b0) begin
            n_bad++;
            $display("FAIL door_open_start: got state=%0d lock=%b want 0/0", state, door_lock);
        end
        door_closed = 1'b1;
        begin_run(1'b0);
        n_cmp++;
        if (state !== 3'd1 || door_lock !== 1'b1) begin
            n_bad++;
            $display("FAIL door_lock_fill: got state=%0d lock=%b want 1/1", state, door_lock);
        end
        while (state !== 3'd4 && guard < 200) begin
            tick_obs();
            guard++;
        end
        door_closed = 1'b0;
        repeat (4) tick_obs();
        n_cmp++;
        if (paused !== 1'b1 || state !== 3'd4 || water_valve !== 1'b0) begin
            n_bad++;
            $display("FAIL door_pause: got paused=%b state=%0d wv=%b want 1/4/0", paused, state, water_valve);
        end
        door_closed = 1'b1;
        run_to_off(400);
        n_cmp++;
        if (timed_out || out_at !== 148) begin
            n_bad++;
            $display("FAIL door_out_timing: got out_at=%0d want 148", out_at);
        end
    endtask
`endif

    initial begin
        start_button = 1'b0;
        pause_button = 1'b0;
        abort        = 1'b0;
        quick_mode   = 1'b0;
`ifdef WM_DOOR_LOCK_EN
        door_closed  = 1'b1;
`endif
        test_reset();
        test_normal();
        test_quick();
        test_pause();
        test_abort();
        test_reset_mid();
`ifdef WM_DOOR_LOCK_EN
        test_door();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
